// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants: default operand width/modulus and op encoding.
package ntt_pkg;
    localparam int   NTT_WIDTH = 12;
    localparam int   NTT_Q     = 3329;
    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_SUB    = 1'b1;
endpackage

// File: rtl/mod_add_sub_if.sv
// Operand/result handshake bundle for mod_add_sub; master = producer/consumer side, slave = the block.
interface mod_add_sub_if #(
    parameter int WIDTH = 12,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, op_sub, a, b, tag_in, out_ready,
        input  in_ready, out_valid, res, tag_out
    );

    modport slave (
        input  in_valid, op_sub, a, b, tag_in, out_ready,
        output in_ready, out_valid, res, tag_out
    );
endinterface

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder from a chain of full-adder cells; purely combinational.
module ripple_carry_adder #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic carry;

    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        cout = carry;
    end
endmodule

// File: rtl/mod_add_sub.sv
// Two-stage valid/ready modular add/sub, 2-cycle latency, holds output and buffers 2 ops under backpressure.
// Optional sticky out-of-range flag via MOD_ADD_SUB_RANGE_CHECK_EN.
module mod_add_sub
    import ntt_pkg::*;
#(
    parameter int WIDTH = NTT_WIDTH,
    parameter int Q     = NTT_Q,
    parameter int TAG_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    mod_add_sub_if.slave   io
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
    ,
    output logic           range_err
`endif
);
    localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);

    logic             v1_q, v1_d;
    logic             op1_q, op1_d;
    logic [WIDTH:0]   t1_q, t1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [TAG_W-1:0] tag_out_q, tag_out_d;

    logic             ld1, ld2, in_xfer;
    logic [WIDTH-1:0] add1_y, sum1, add2_y, sum2;
    logic             cout1, cout2, use_corr;

    assign ld2     = !v2_q || io.out_ready;
    assign ld1     = !v1_q || ld2;
    assign in_xfer = io.in_valid && ld1;

    // Subtract as a + ~b + 1 so the carry out is the inverted borrow.
    assign add1_y = (io.op_sub == OP_SUB) ? ~io.b : io.b;

    ripple_carry_adder #(.WIDTH(WIDTH)) u_stage1_add (
        .x    (io.a),
        .y    (add1_y),
        .cin  (io.op_sub),
        .sum  (sum1),
        .cout (cout1)
    );

    // Add path subtracts Q (carry out => low part >= Q); sub path adds Q back.
    assign add2_y = (op1_q == OP_SUB) ? Q_W : ~Q_W;

    ripple_carry_adder #(.WIDTH(WIDTH)) u_stage2_corr (
        .x    (t1_q[WIDTH-1:0]),
        .y    (add2_y),
        .cin  (op1_q == OP_ADD),
        .sum  (sum2),
        .cout (cout2)
    );

    assign use_corr = (op1_q == OP_SUB) ? !t1_q[WIDTH] : (t1_q[WIDTH] || cout2);

    always_comb begin
        v1_d      = ld1 ? io.in_valid : v1_q;
        op1_d     = op1_q;
        t1_d      = t1_q;
        tag1_d    = tag1_q;
        v2_d      = ld2 ? v1_q : v2_q;
        res_d     = res_q;
        tag_out_d = tag_out_q;
        if (in_xfer) begin
            op1_d  = io.op_sub;
            t1_d   = {cout1, sum1};
            tag1_d = io.tag_in;
        end
        if (ld2 && v1_q) begin
            res_d     = use_corr ? sum2 : t1_q[WIDTH-1:0];
            tag_out_d = tag1_q;
        end
    end

`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
    logic range_err_q, range_err_d;

    always_comb begin
        range_err_d = range_err_q || (in_xfer && ((io.a >= Q_W) || (io.b >= Q_W)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) range_err_q <= 1'b0;
        else     range_err_q <= range_err_d;
    end

    assign range_err = range_err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= 1'b0;
            op1_q     <= OP_ADD;
            t1_q      <= '0;
            tag1_q    <= '0;
            v2_q      <= 1'b0;
            res_q     <= '0;
            tag_out_q <= '0;
        end else begin
            v1_q      <= v1_d;
            op1_q     <= op1_d;
            t1_q      <= t1_d;
            tag1_q    <= tag1_d;
            v2_q      <= v2_d;
            res_q     <= res_d;
            tag_out_q <= tag_out_d;
        end
    end

    assign io.in_ready  = ld1;
    assign io.out_valid = v2_q;
    assign io.res       = res_q;
    assign io.tag_out   = tag_out_q;
endmodule

// File: tb/tb_mod_add_sub.sv
// Randomised and directed bench for mod_add_sub against a queue-based arithmetic reference model.
module tb_mod_add_sub;
    localparam int W  = 12;
    localparam int QM = 3329;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_add_sub_if #(.WIDTH(W), .TAG_W(TW)) bus ();

`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
    logic range_err;
`endif

    mod_add_sub #(.WIDTH(W), .Q(QM), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
        ,
        .range_err (range_err)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned golden(input bit sub, input int unsigned a, input int unsigned b);
        if (!sub) return (a + b) % QM;
        return (a + QM - b) % QM;
    endfunction

    typedef struct {
        int unsigned res;
        int unsigned tag;
        bit          care;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_in  = 0;
    int          n_out = 0;
    int unsigned seen_tags[$];
    bit          held_v = 0;
    logic [W-1:0]  held_res;
    logic [TW-1:0] held_tag;

    // Scoreboard: observes both handshakes every cycle away from the clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                held_v = 0;
            end else begin
                if (held_v) begin
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_res", bus.res, held_res);
                    check("stall_tag", bus.tag_out, held_tag);
                end
                if (bus.out_valid && bus.out_ready) begin
                    n_out++;
                    seen_tags.push_back(bus.tag_out);
                    if (q.size() == 0) begin
                        check("spurious_out", 1, 0);
                    end else begin
                        e = q.pop_front();
                        if (e.care) begin
                            check("res", bus.res, e.res);
                            check("tag", bus.tag_out, e.tag);
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    n_in++;
                    e.res  = golden(bus.op_sub, bus.a, bus.b);
                    e.tag  = bus.tag_in;
                    e.care = (bus.a < QM) && (bus.b < QM);
                    q.push_back(e);
                end
                held_v   = bus.out_valid && !bus.out_ready;
                held_res = bus.res;
                held_tag = bus.tag_out;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive(input bit v, input bit sub, input int unsigned a, input int unsigned b,
                         input int unsigned tg);
        bus.in_valid = v;
        bus.op_sub   = sub;
        bus.a        = W'(a);
        bus.b        = W'(b);
        bus.tag_in   = TW'(tg);
    endtask

    // One op into an empty pipe with out_ready high; checks the exact 2-cycle latency.
    task automatic lat_op(input string tg, input bit sub, input int unsigned a, input int unsigned b,
                          input int unsigned exp_res);
        @(posedge clk); #1;
        drive(1, sub, a, b, 7);
        bus.out_ready = 1;
        @(negedge clk);
        check({tg, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 0;
        @(negedge clk);
        check({tg, "_cyc1_valid"}, bus.out_valid, 0);
        @(negedge clk);
        check({tg, "_cyc2_valid"}, bus.out_valid, 1);
        check({tg, "_res"}, bus.res, exp_res);
    endtask

    task automatic drain(input string tg);
        @(posedge clk); #1;
        bus.in_valid  = 0;
        bus.out_ready = 1;
        repeat (8) @(negedge clk);
        #1;
        check({tg, "_queue_empty"}, q.size(), 0);
        check({tg, "_idle"}, bus.out_valid, 0);
    endtask

    int unsigned t_sub [7] = '{0, 0, 0, 1, 1, 1, 1};
    int unsigned t_a   [7] = '{3000, 1664, 3328, 5, 10, 0, 7};
    int unsigned t_b   [7] = '{1000, 1665, 0, 10, 5, 3328, 7};
    int unsigned t_exp [7] = '{671, 0, 3328, 3324, 5, 1, 0};

    initial begin
        bit acc;
        int sent, guard, in0, out0;

        rst = 1;
        drive(0, 0, 0, 0, 0);
        bus.out_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_res", bus.res, 0);
        check("rst_tag_out", bus.tag_out, 0);
`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
        check("rst_range_err", range_err, 0);
`endif
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            lat_op($sformatf("dir%0d", i), t_sub[i], t_a[i], t_b[i], t_exp[i]);
        end
        drain("dir");

        // Backpressure: two ops fill the pipe, third is refused until out_ready returns.
        seen_tags.delete();
        @(posedge clk); #1;
        bus.out_ready = 0;
        drive(1, 0, 100, 200, 1);
        @(negedge clk);
        check("bp_rdy1", bus.in_ready, 1);
        @(posedge clk); #1;
        drive(1, 1, 300, 400, 2);
        @(negedge clk);
        check("bp_rdy2", bus.in_ready, 1);
        @(posedge clk); #1;
        drive(1, 0, 3000, 3000, 3);
        @(negedge clk);
        check("bp_rdy3", bus.in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_rdy3_hold", bus.in_ready, 0);
        check("bp_res_tag1", bus.res, 300);
        @(posedge clk); #1;
        bus.out_ready = 1;
        @(negedge clk);
        check("bp_rdy_release", bus.in_ready, 1);
        drain("bp");
        check("bp_count", seen_tags.size(), 3);
        if (seen_tags.size() == 3) begin
            check("bp_order0", seen_tags[0], 1);
            check("bp_order1", seen_tags[1], 2);
            check("bp_order2", seen_tags[2], 3);
        end

        // Streaming with continuous in_valid and random out_ready.
        in0 = n_in; out0 = n_out; sent = 0; guard = 0; acc = 1;
        while (sent < 100 && guard < 5000) begin
            @(posedge clk); #1;
            if (acc) drive(1, 1'($urandom_range(0, 1)), $urandom_range(0, QM - 1),
                           $urandom_range(0, QM - 1), $urandom_range(0, 15));
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) sent++;
            guard++;
        end
        check("stream_sent", sent, 100);
        drain("stream");
        check("stream_in_count", n_in - in0, 100);
        check("stream_out_count", n_out - out0, 100);

        // Reset with two ops in flight.
        @(posedge clk); #1;
        bus.out_ready = 0;
        drive(1, 0, 11, 22, 4);
        @(posedge clk); #1;
        drive(1, 1, 33, 44, 5);
        @(posedge clk); #1;
        bus.in_valid = 0;
        @(negedge clk);
        check("pre_rst_valid", bus.out_valid, 1);
        @(posedge clk); #1;
        rst = 1;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_res", bus.res, 0);
        check("mid_rst_tag", bus.tag_out, 0);
        @(posedge clk); #1;
        rst = 0;
        bus.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale", bus.out_valid, 0);
        end
        lat_op("post_rst", 0, 1000, 2500, 171);
        drain("post_rst");

`ifdef MOD_ADD_SUB_RANGE_CHECK_EN
        @(negedge clk);
        check("rerr_clear", range_err, 0);
        @(posedge clk); #1;
        drive(1, 0, 3329, 0, 9);
        @(posedge clk); #1;
        drive(1, 0, 1, 2, 10);
        @(negedge clk);
        check("rerr_set", range_err, 1);
        @(posedge clk); #1;
        drive(1, 1, 20, 3, 11);
        @(negedge clk);
        check("rerr_sticky1", range_err, 1);
        drain("rerr");
        check("rerr_sticky2", range_err, 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("rerr_rst", range_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
